ysyx_mem_arbiter: RTL

//  Two-requester memory arbiter for the NPC core. It shares the single memory port

---
 rtl/ysyx_mem_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_mem_arbiter.sv
// Two-requester memory arbiter: IFU (m0) and LSU (m1) share one memory port,
// one transaction outstanding, round-robin on ties.
// Optional response timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module ysyx_mem_arbiter #(
  parameter int unsigned LSU_FIRST = 1,
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [31:0] m0_addr,
  input  logic        m0_wen,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic        m0_rsp_valid,
  output logic [31:0] m0_rsp_rdata,
  output logic        m0_rsp_err,

  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic [31:0] m1_addr,
  input  logic        m1_wen,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic        m1_rsp_valid,
  output logic [31:0] m1_rsp_rdata,
  output logic        m1_rsp_err,

  output logic        s_req_valid,
  input  logic        s_req_ready,
  output logic [31:0] s_addr,
  output logic        s_wen,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  input  logic        s_rsp_valid,
  input  logic [31:0] s_rsp_rdata,
  input  logic        s_rsp_err
);

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } state_e;

  localparam logic PtrInit = (LSU_FIRST != 0);

  state_e state_q, state_d;
  logic   ptr_q, ptr_d;      // master favoured on a tie: 0 = m0, 1 = m1
  logic   owner_q, owner_d;  // master whose transaction is outstanding

  logic        winner;
  logic        rsp_fire;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] ToLimit = 8'(TO_CYCLES);

  logic [7:0] cnt_q, cnt_d;

  // Timeout counter: counts WAIT cycles of the outstanding transaction
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_to_cycles;
  assign unused_to_cycles = ^TO_CYCLES;
`endif

  // State, priority pointer and owner registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= PtrInit;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Winner selection: a lone requester wins, a tie goes to the pointer
  always_comb begin
    winner = 1'b0;
    if (m0_req_valid && m1_req_valid) begin
      winner = ptr_q;
    end else begin
      winner = m1_req_valid;
    end
  end

  // Next-state logic, request mux and response capture
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    s_req_valid  = 1'b0;
    s_addr       = 32'h0;
    s_wen        = 1'b0;
    s_wdata      = 32'h0;
    s_wmask      = 4'h0;
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
    rsp_fire     = 1'b0;
    rsp_rdata    = 32'h0;
    rsp_err      = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        // Any s_rsp_valid seen here is stale and simply ignored
        if (m0_req_valid || m1_req_valid) begin
          s_req_valid = 1'b1;
          if (winner) begin
            s_addr       = m1_addr;
            s_wen        = m1_wen;
            s_wdata      = m1_wdata;
            s_wmask      = m1_wmask;
            m1_req_ready = s_req_ready;
          end else begin
            s_addr       = m0_addr;
            s_wen        = m0_wen;
            s_wdata      = m0_wdata;
            s_wmask      = m0_wmask;
            m0_req_ready = s_req_ready;
          end
          if (s_req_ready) begin
            owner_d = winner;
            state_d = StWait;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
          end
        end
      end

      StWait: begin
        if (s_rsp_valid) begin
          rsp_fire  = 1'b1;
          rsp_rdata = s_rsp_rdata;
          rsp_err   = s_rsp_err;
          ptr_d     = ~owner_q;
          state_d   = StIdle;
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (cnt_q + 8'd1 == ToLimit) begin
          // Memory went silent: answer the owner with an error ourselves
          rsp_fire  = 1'b1;
          rsp_rdata = 32'h0;
          rsp_err   = 1'b1;
          ptr_d     = ~owner_q;
          state_d   = StIdle;
        end else begin
          cnt_d     = cnt_q + 8'd1;
`endif
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Everything handed to masters or memory stays quiet while reset is held
    if (!reset) begin
      s_req_valid  = 1'b0;
      s_addr       = 32'h0;
      s_wen        = 1'b0;
      s_wdata      = 32'h0;
      s_wmask      = 4'h0;
      m0_req_ready = 1'b0;
      m1_req_ready = 1'b0;
      rsp_fire     = 1'b0;
      rsp_rdata    = 32'h0;
      rsp_err      = 1'b0;
    end
  end

  // Response routing: only the owner ever sees a response
  always_comb begin
    m0_rsp_valid = rsp_fire & ~owner_q;
    m0_rsp_rdata = (rsp_fire & ~owner_q) ? rsp_rdata : 32'h0;
    m0_rsp_err   = rsp_err & rsp_fire & ~owner_q;
    m1_rsp_valid = rsp_fire & owner_q;
    m1_rsp_rdata = (rsp_fire & owner_q) ? rsp_rdata : 32'h0;
    m1_rsp_err   = rsp_err & rsp_fire & owner_q;
  end

endmodule
